// File: rtl/ld_st_pkg.sv
// ld_st_pkg: shared encodings for the load/store register controller
package ld_st_pkg;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_LOAD = 2'b01, OP_CLEAR = 2'b10, OP_SET = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_EXEC = 2'b01, ST_ACK = 2'b10} state_e;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/ld_st_rr_pick.sv
// ld_st_rr_pick: two-way round-robin picker favouring the requester not granted last
import ld_st_pkg::*;
module ld_st_rr_pick (
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic valid,
  output logic winner
);
  always_comb begin
    valid  = req_a | req_b;
    winner = (req_a & req_b) ? ((last_grant == REQ_A) ? REQ_B : REQ_A) : (req_b ? REQ_B : REQ_A);
  end
endmodule

// File: rtl/ld_st_reg_ctrl.sv
// ld_st_reg_ctrl: arbitrates two requesters and sequences one shared load/store register
import ld_st_pkg::*;
module ld_st_reg_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  input  logic [WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0] reg_d,
  output logic             reg_clr_n,
  output logic             reg_set_n
);
  state_e           state, nxt;
  op_e              op_r;
  logic [WIDTH-1:0] wdata_r;
  logic             last_grant, valid, winner, win_req, exec;
  ld_st_rr_pick u_pick (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .valid      (valid),
    .winner     (winner)
  );
  always_comb begin
    exec    = state == ST_EXEC;
    win_req = (last_grant == REQ_A) ? req_a : req_b;
    nxt     = (state == ST_IDLE) ? (valid ? ST_EXEC : ST_IDLE) :
              (state == ST_EXEC) ? ST_ACK : (win_req ? ST_ACK : ST_IDLE);
    busy      = state != ST_IDLE;
    ack_a     = (state == ST_ACK) && (last_grant == REQ_A);
    ack_b     = (state == ST_ACK) && (last_grant == REQ_B);
    reg_d     = (exec && op_r == OP_LOAD) ? wdata_r : reg_q;
    reg_clr_n = clr & ~(exec && op_r == OP_CLEAR);
    reg_set_n = ~(exec && op_r == OP_SET);
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= ST_IDLE;
      last_grant <= REQ_B;
      op_r       <= OP_READ;
      wdata_r    <= '0;
      rdata      <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && valid) begin
        last_grant <= winner;
        op_r       <= (winner == REQ_A) ? op_e'(op_a) : op_e'(op_b);
        wdata_r    <= (winner == REQ_A) ? wdata_a : wdata_b;
      end
      if (exec && op_r == OP_READ) rdata <= reg_q;
    end
  end
endmodule
